// File: rtl/nvram_pkg.sv
// Shared definitions for the NVR_TOP host sequencer: FSM encoding, default
// timing constants and the bus widths used by NVR_TOP wrappers.
package nvram_pkg;

   localparam int DEFAULT_ADDR_W        = 7;
   localparam int DEFAULT_DATA_W        = 32;
   localparam int DEFAULT_SETUP_CYC     = 2;
   localparam int DEFAULT_CE_CYC        = 1;
   localparam int DEFAULT_WE_HOLD_CYC   = 7;
   localparam int DEFAULT_RDY_MASK_CYC  = 2;
   localparam int DEFAULT_POR_PRE_CYC   = 10;
   localparam int DEFAULT_POR_PULSE_CYC = 10;
   localparam int DEFAULT_POR_POST_CYC  = 10;
   localparam int DEFAULT_TIMEOUT_CYC   = 64;

   typedef enum logic [3:0] {
      S_PRE    = 4'd0,
      S_POR    = 4'd1,
      S_POST   = 4'd2,
      S_IDLE   = 4'd3,
      S_SETUP  = 4'd4,
      S_STROBE = 4'd5,
      S_HOLD   = 4'd6,
      S_WAIT   = 4'd7,
      S_RESP   = 4'd8
   } nv_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/nvram_sync2.sv
// Two-flop synchronizer for a single asynchronous level; output resets to 0.
module nvram_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/nvram_ctrl.sv
// NVR_TOP host sequencer: POR pulse sequence, then single-beat read/write transfers.
// Define NVRAM_TIMEOUT_EN to bound the RDY wait and report rsp_err on expiry.
module nvram_ctrl
   import nvram_pkg::*;
#(
   parameter int ADDR_W        = DEFAULT_ADDR_W,
   parameter int DATA_W        = DEFAULT_DATA_W,
   parameter int SETUP_CYC     = DEFAULT_SETUP_CYC,
   parameter int CE_CYC        = DEFAULT_CE_CYC,
   parameter int WE_HOLD_CYC   = DEFAULT_WE_HOLD_CYC,
   parameter int RDY_MASK_CYC  = DEFAULT_RDY_MASK_CYC,
   parameter int POR_PRE_CYC   = DEFAULT_POR_PRE_CYC,
   parameter int POR_PULSE_CYC = DEFAULT_POR_PULSE_CYC,
   parameter int POR_POST_CYC  = DEFAULT_POR_POST_CYC
`ifdef NVRAM_TIMEOUT_EN
   , parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              init_done,
   output logic [ADDR_W-1:0] nv_a,
   output logic [DATA_W-1:0] nv_din,
   output logic              nv_ce,
   output logic              nv_we,
   output logic              nv_por,
   output logic              nv_hs,
   output logic              nv_hr,
   input  logic [DATA_W-1:0] nv_dout,
   input  logic              nv_rdy
);

`ifdef NVRAM_TIMEOUT_EN
   localparam int WAIT_MAX = RDY_MASK_CYC + TIMEOUT_CYC;
`else
   localparam int WAIT_MAX = RDY_MASK_CYC;
`endif
   localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, CE_CYC), max_int(WE_HOLD_CYC, WAIT_MAX)),
                                    max_int(POR_PRE_CYC, max_int(POR_PULSE_CYC, POR_POST_CYC)));
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(POR_PRE_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(POR_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] POST_LAST  = CNT_W'(POR_POST_CYC - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] CE_LAST    = CNT_W'(CE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(WE_HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] MASK_C     = CNT_W'(RDY_MASK_CYC);

   nv_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              op_we_q, op_we_d;
   logic [ADDR_W-1:0] nv_a_q, nv_a_d;
   logic [DATA_W-1:0] nv_din_q, nv_din_d;
   logic              nv_ce_q, nv_ce_d;
   logic              nv_we_q, nv_we_d;
   logic              nv_por_q, nv_por_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              init_done_q, init_done_d;

   logic              rdy_s;
   logic              accept_s;
   logic              mask_s;
   logic              timeout_s;

   nvram_sync2 u_rdy_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (nv_rdy),
      .q     (rdy_s)
   );

   assign accept_s = (state_q == S_IDLE) && req_valid && req_ready_q;
   assign mask_s   = (cnt_q < MASK_C);

   // In S_WAIT the counter keeps running past the mask window only when a timeout is built.
`ifdef NVRAM_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RDY_MASK_CYC + TIMEOUT_CYC - 1);
   assign timeout_s = (state_q == S_WAIT) && !mask_s && !rdy_s && (cnt_q == TO_LAST);
`else
   assign timeout_s = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_PRE;
         cnt_q       <= CNT_ZERO;
         op_we_q     <= 1'b0;
         nv_a_q      <= {ADDR_W{1'b0}};
         nv_din_q    <= {DATA_W{1'b0}};
         nv_ce_q     <= 1'b0;
         nv_we_q     <= 1'b0;
         nv_por_q    <= 1'b0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= {DATA_W{1'b0}};
         rsp_err_q   <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_we_q     <= op_we_d;
         nv_a_q      <= nv_a_d;
         nv_din_q    <= nv_din_d;
         nv_ce_q     <= nv_ce_d;
         nv_we_q     <= nv_we_d;
         nv_por_q    <= nv_por_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         init_done_q <= init_done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_ONE;
      case (state_q)
         S_PRE: begin
            if (cnt_q == PRE_LAST) begin
               state_d = S_POR;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = S_PRE;
            end
         end
         S_POR: begin
            if (cnt_q == PULSE_LAST) begin
               state_d = S_POST;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = S_POR;
            end
         end
         S_POST: begin
            if (cnt_q == POST_LAST) begin
               state_d = S_IDLE;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = S_POST;
            end
         end
         S_IDLE: begin
            cnt_d = CNT_ZERO;
            if (accept_s) begin
               state_d = S_SETUP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = S_STROBE;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = S_SETUP;
            end
         end
         S_STROBE: begin
            if (cnt_q == CE_LAST) begin
               state_d = op_we_q ? S_HOLD : S_WAIT;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = S_STROBE;
            end
         end
         S_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = S_WAIT;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = S_HOLD;
            end
         end
         S_WAIT: begin
            if (mask_s) begin
               state_d = S_WAIT;
            end else if (rdy_s || timeout_s) begin
               state_d = S_RESP;
               cnt_d   = CNT_ZERO;
            end else begin
               state_d = S_WAIT;
`ifndef NVRAM_TIMEOUT_EN
               cnt_d   = cnt_q;
`endif
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
         end
         default: begin
            state_d = S_PRE;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // Outputs are computed from the state being entered so the flops line up with it.
   always_comb begin
      nv_por_d    = 1'b0;
      nv_ce_d     = 1'b0;
      nv_we_d     = nv_we_q;
      req_ready_d = 1'b0;
      init_done_d = init_done_q;
      case (state_d)
         S_POR:    nv_por_d = 1'b1;
         S_IDLE: begin
            req_ready_d = 1'b1;
            init_done_d = 1'b1;
         end
         S_STROBE: nv_ce_d = 1'b1;
         S_WAIT:   nv_we_d = 1'b0;
         default:  nv_por_d = 1'b0;
      endcase

      if (accept_s) begin
         nv_a_d   = req_addr;
         nv_we_d  = req_we;
         op_we_d  = req_we;
         nv_din_d = req_we ? req_wdata : nv_din_q;
      end else begin
         nv_a_d   = nv_a_q;
         op_we_d  = op_we_q;
         nv_din_d = nv_din_q;
      end

      if ((state_q == S_WAIT) && (state_d == S_RESP)) begin
         rsp_err_d   = timeout_s;
         rsp_rdata_d = (!op_we_q && !timeout_s) ? nv_dout : rsp_rdata_q;
      end else begin
         rsp_err_d   = rsp_err_q;
         rsp_rdata_d = rsp_rdata_q;
      end

      rsp_valid_d = (state_q == S_RESP);
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign init_done = init_done_q;
   assign nv_a      = nv_a_q;
   assign nv_din    = nv_din_q;
   assign nv_ce     = nv_ce_q;
   assign nv_we     = nv_we_q;
   assign nv_por    = nv_por_q;
   assign nv_hs     = 1'b0;
   assign nv_hr     = 1'b0;

endmodule

// File: tb/tb_nvram_ctrl.sv
// Self-checking bench for nvram_ctrl: behavioural macro, reference memory and
// timing rules; exercises POR, reads/writes, RDY delay, reset mid-write, timeout.
module tb_nvram_ctrl;
   import nvram_pkg::*;

   localparam int AW      = DEFAULT_ADDR_W;
   localparam int DW      = DEFAULT_DATA_W;
   localparam int SETUP   = DEFAULT_SETUP_CYC;
   localparam int CE      = DEFAULT_CE_CYC;
   localparam int HOLD    = DEFAULT_WE_HOLD_CYC;
   localparam int MASK    = DEFAULT_RDY_MASK_CYC;
   localparam int TIMEOUT = DEFAULT_TIMEOUT_CYC;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_err, init_done;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] nv_a;
   logic [DW-1:0] nv_din, nv_dout;
   logic          nv_ce, nv_we, nv_por, nv_hs, nv_hr, nv_rdy;

   logic          pre_en;
   logic [AW-1:0] pre_addr;
   logic [DW-1:0] pre_data;
   logic [DW-1:0] mem     [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   logic [DW-1:0] last_rdata;
   logic [DW-1:0] last_din;

   int n_checks = 0;
   int n_fail   = 0;

   nvram_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .init_done (init_done),
      .nv_a      (nv_a),
      .nv_din    (nv_din),
      .nv_ce     (nv_ce),
      .nv_we     (nv_we),
      .nv_por    (nv_por),
      .nv_hs     (nv_hs),
      .nv_hr     (nv_hr),
      .nv_dout   (nv_dout),
      .nv_rdy    (nv_rdy)
   );

   always #5 clk = ~clk;

   // Macro model: preload port for the bench, write on a CE strobe with WE high.
   always @(posedge clk) begin
      if (pre_en) mem[pre_addr] = pre_data;
      else if (nv_ce && nv_we) mem[nv_a] = nv_din;
   end
   assign nv_dout = mem[nv_a];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Expected POR timeline counted in clock edges after rst_n release.
   task automatic por_check();
      logic activity;
      activity  = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = AW'($urandom);
      for (int k = 1; k <= 32; k++) begin
         @(posedge clk); #1;
         chk("por_pin", 32'(nv_por), 32'((k >= 10) && (k < 20)));
         chk("init_done", 32'(init_done), 32'(k >= 30));
         chk("req_ready_por", 32'(req_ready), 32'(k >= 30));
         if (nv_ce || rsp_valid) activity = 1'b1;
         if (k == 29) req_valid = 1'b0;
      end
      chk("no_access_before_init", 32'(activity), 32'd0);
   endtask

   task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input int rise_k, input int rst_k);
      int            exp_lat, got_lat, ce_first, ce_cnt, we_fall, ln;
      logic          we_at0, a_bad, din_bad, rd_we_bad, got_err, never;
      logic [DW-1:0] got_rdata, exp_rdata;
      got_lat = -1; ce_first = -1; ce_cnt = 0; we_fall = -1;
      we_at0 = 1'b0; a_bad = 1'b0; din_bad = 1'b0; rd_we_bad = 1'b0; got_err = 1'b0;
      got_rdata = '0;
      never = (rise_k >= 1000);
      if (rise_k >= 0) begin
         nv_rdy = 1'b0;
         repeat (3) begin @(posedge clk); #1; end
      end
      for (int i = 0; i < 50 && req_ready !== 1'b1; i++) begin @(posedge clk); #1; end
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      if (req_ready !== 1'b1) return;

      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;

      // Latency rule: 1 + setup + strobe [+ hold] + max(mask, rdy delay + 2) + 1.
      ln = (rise_k < 0) ? 0 : rise_k - (SETUP + CE + (we ? HOLD : 0));
      if (never) exp_lat = SETUP + CE + MASK + TIMEOUT + 1;
      else       exp_lat = 1 + SETUP + CE + (we ? HOLD : 0) + max_int(MASK, ln + 2) + 1;
      exp_rdata = (we || never) ? last_rdata : ref_mem[addr];
      if (we) ref_mem[addr] = data;

      for (int k = 0; k <= 150; k++) begin
         if (k == 0) we_at0 = nv_we;
         if (nv_ce === 1'b1) begin
            if (ce_first < 0) ce_first = k;
            ce_cnt++;
         end
         if (got_lat < 0) begin
            if (nv_a !== addr) a_bad = 1'b1;
            if (nv_din !== (we ? data : last_din)) din_bad = 1'b1;
            if (!we && nv_we !== 1'b0) rd_we_bad = 1'b1;
            if (we && we_fall < 0 && nv_we === 1'b0) we_fall = k;
         end
         if (k == rst_k) begin
            rst_n = 1'b0;
            #1;
            chk("rst_nv_we", 32'(nv_we), 32'd0);
            chk("rst_nv_ce", 32'(nv_ce), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            return;
         end
         if (got_lat >= 0) begin
            chk("rsp_valid_one_cycle", 32'(rsp_valid), 32'd0);
            break;
         end
         if (rsp_valid === 1'b1) begin
            got_lat   = k;
            got_rdata = rsp_rdata;
            got_err   = rsp_err;
         end
         if (k == rise_k) nv_rdy = 1'b1;
         @(posedge clk); #1;
      end

      chk("rsp_latency", 32'(got_lat), 32'(exp_lat));
      chk("rsp_rdata", got_rdata, exp_rdata);
      chk("rsp_err", 32'(got_err), 32'(never));
      chk("ce_rise", 32'(ce_first), 32'(SETUP));
      chk("ce_width", 32'(ce_cnt), 32'(CE));
      chk("nv_a_stable", 32'(a_bad), 32'd0);
      chk("nv_din_stable", 32'(din_bad), 32'd0);
      if (we) begin
         chk("we_setup_lead", 32'(we_at0), 32'd1);
         chk("we_hold_fall", 32'(we_fall), 32'(SETUP + CE + HOLD));
         last_din = data;
      end else begin
         chk("rd_we_low", 32'(rd_we_bad), 32'd0);
         if (!never) last_rdata = exp_rdata;
      end
      if (nv_rdy !== 1'b1) begin
         nv_rdy = 1'b1;
         repeat (3) begin @(posedge clk); #1; end
      end
   endtask

   initial begin
      logic          rw;
      logic [AW-1:0] ra;
      logic [DW-1:0] rd;
      int            rk;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      nv_rdy = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
      last_rdata = '0; last_din = '0;

      @(posedge clk); #1;
      for (int i = 0; i < (1 << AW); i++) begin
         pre_addr   = AW'(i);
         pre_data   = (i == 5) ? 32'h1234_5678 : $urandom;
         ref_mem[i] = pre_data;
         pre_en     = 1'b1;
         @(posedge clk); #1;
      end
      pre_en = 1'b0;

      chk("reset_ctrl_bits", {23'd0, nv_por, nv_ce, nv_we, nv_hs, nv_hr, req_ready, rsp_valid, rsp_err, init_done},
          32'd0);
      chk("reset_nv_a", 32'(nv_a), 32'd0);
      chk("reset_nv_din", nv_din, 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);

      #1 rst_n = 1'b1;
      por_check();

      do_txn(1'b0, 7'h05, 32'h0, -1, -1);
      do_txn(1'b1, 7'h7F, 32'hDEAD_BEEF, -1, -1);
      do_txn(1'b0, 7'h7F, 32'h0, -1, -1);
      do_txn(1'b0, 7'h05, 32'h0, SETUP + CE + 20, -1);

      for (int n = 0; n < 24; n++) begin
         rw = 1'($urandom_range(0, 1));
         ra = AW'($urandom);
         rd = $urandom;
         rk = (rw || ($urandom_range(0, 2) != 0)) ? -1 : SETUP + CE + $urandom_range(0, 10);
         do_txn(rw, ra, rd, rk, -1);
      end

`ifdef NVRAM_TIMEOUT_EN
      do_txn(1'b0, 7'h11, 32'h0, 100000, -1);
      do_txn(1'b0, 7'h12, 32'h0, -1, -1);
`endif

      do_txn(1'b1, 7'h22, 32'hCAFE_F00D, -1, SETUP + CE + 3);
      repeat (2) begin
         @(posedge clk); #1;
         chk("in_reset_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      last_rdata = '0;
      last_din   = '0;
      chk("reset_clears_rdata", rsp_rdata, 32'd0);
      #1 rst_n = 1'b1;
      por_check();
      do_txn(1'b0, 7'h22, 32'h0, -1, -1);
      do_txn(1'b0, 7'h7F, 32'h0, -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
